regf_apb2mem: RTL and testbench

//  - APB slave to register-file memory-port bridge; sits directly upstream of *_regf blocks.
//  - Converts APB3 transfers into one-cycle mem_ena/mem_wena accesses.
//  - Inserts wait states until the regf read data / error is captured.
//  - Rejects misaligned transfers locally, without touching the mem port.

---
 rtl/regf_apb2mem.sv | 194 +++++++++++++++++++
 tb/tb_regf_apb2mem.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regf_apb2mem.sv
// -----------------------------------------------------------------------------
// regf_apb2mem
//   APB slave to register-file memory-port bridge.
//   Each accepted APB transfer becomes a single-cycle mem_ena_o access. The
//   bridge holds off pready_o until the regf read data / error has been
//   sampled RLAT cycles later. Misaligned transfers are rejected locally with
//   pslverr_o and never reach the mem port.
//
//   Optional build macro: REGF_APB2MEM_STRB_EN
//     Adds apb_pstrb_i (APB4 byte strobes). A write whose strobes are not all
//     ones is rejected with pslverr_o and no mem access. Reads ignore pstrb.
//     Without the macro the port is absent and every write is a full word.
// -----------------------------------------------------------------------------
module regf_apb2mem #(
    parameter int ADDRW = 13,
    parameter int DATAW = 32,
    parameter int RLAT  = 1
) (
    input  logic               main_clk_i,
    input  logic               main_rst_an_i,
    input  logic               apb_psel_i,
    input  logic               apb_penable_i,
    input  logic               apb_pwrite_i,
    input  logic [ADDRW+1:0]   apb_paddr_i,
    input  logic [DATAW-1:0]   apb_pwdata_i,
`ifdef REGF_APB2MEM_STRB_EN
    input  logic [DATAW/8-1:0] apb_pstrb_i,
`endif
    output logic [DATAW-1:0]   apb_prdata_o,
    output logic               apb_pready_o,
    output logic               apb_pslverr_o,
    output logic               mem_ena_o,
    output logic [ADDRW-1:0]   mem_addr_o,
    output logic               mem_wena_o,
    output logic [DATAW-1:0]   mem_wdata_o,
    input  logic [DATAW-1:0]   mem_rdata_i,
    input  logic               mem_err_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACC,
        S_WAIT,
        S_RESP,
        S_ERR
    } state_t;

    // RLAT=0 means the regf answers in the same cycle as mem_ena_o, so the
    // sample happens directly from ACC and the WAIT state is never entered.
    localparam bit       NO_WAIT  = (RLAT == 0);
    localparam logic [2:0] CNT_INIT = (RLAT > 0) ? 3'(RLAT - 1) : 3'd0;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic               r_write;
    logic               r_abort;
    logic [DATAW-1:0]   r_prdata;
    logic               r_pready;
    logic               r_pslverr;
    logic               r_mem_ena;
    logic [ADDRW-1:0]   r_mem_addr;
    logic               r_mem_wena;
    logic [DATAW-1:0]   r_mem_wdata;

    logic               w_setup;
    logic               w_misalign;
    logic               w_strb_bad;
    logic               w_sample;
    logic               w_keep;

    // Setup-phase decode and local rejection conditions
    assign w_setup    = apb_psel_i && !apb_penable_i;
    assign w_misalign = |apb_paddr_i[1:0];
`ifdef REGF_APB2MEM_STRB_EN
    assign w_strb_bad = apb_pwrite_i && !(&apb_strb_full(apb_pstrb_i));
`else
    assign w_strb_bad = 1'b0;
`endif

    // Cycle in which the regf read data / error is valid and gets captured
    assign w_sample = (r_state == S_ACC  && NO_WAIT) ||
                      (r_state == S_WAIT && r_cnt == 3'd0);

    // Response is only delivered if the master kept psel up the whole time
    assign w_keep = !r_abort && apb_psel_i;

`ifdef REGF_APB2MEM_STRB_EN
    // Identity helper kept as a function so the strobe test reads as a
    // single all-lanes-enabled reduction at the use site.
    function automatic logic [DATAW/8-1:0] apb_strb_full(input logic [DATAW/8-1:0] strb);
        return strb;
    endfunction
`endif

    // Bridge FSM with registered APB and mem-port outputs
    always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
        if (!main_rst_an_i) begin
            r_state     <= S_IDLE;
            r_cnt       <= 3'd0;
            r_write     <= 1'b0;
            r_abort     <= 1'b0;
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_mem_ena   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wena  <= 1'b0;
            r_mem_wdata <= '0;
        end else begin
            // Strobes and response fields are single-cycle pulses; the
            // states below raise them only in the cycle they are valid.
            r_prdata    <= '0;
            r_pready    <= 1'b0;
            r_pslverr   <= 1'b0;
            r_mem_ena   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wena  <= 1'b0;
            r_mem_wdata <= '0;

            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (w_setup) begin
                        if (w_misalign || w_strb_bad) begin
                            r_state   <= S_ERR;
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                        end else begin
                            r_state     <= S_ACC;
                            r_write     <= apb_pwrite_i;
                            r_mem_ena   <= 1'b1;
                            r_mem_addr  <= apb_paddr_i[ADDRW+1:2];
                            r_mem_wena  <= apb_pwrite_i;
                            r_mem_wdata <= apb_pwdata_i;
                        end
                    end
                end

                S_ACC: begin
                    if (!apb_psel_i) begin
                        r_abort <= 1'b1;
                    end
                    if (!w_sample) begin
                        r_state <= S_WAIT;
                        r_cnt   <= CNT_INIT;
                    end
                end

                S_WAIT: begin
                    if (!apb_psel_i) begin
                        r_abort <= 1'b1;
                    end
                    if (!w_sample) begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                S_ERR: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Capture of the regf answer; an abandoned transfer is dropped
            if (w_sample) begin
                r_cnt <= 3'd0;
                if (w_keep) begin
                    r_state   <= S_RESP;
                    r_pready  <= 1'b1;
                    r_pslverr <= mem_err_i;
                    r_prdata  <= r_write ? '0 : mem_rdata_i;
                end else begin
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign apb_prdata_o  = r_prdata;
    assign apb_pready_o  = r_pready;
    assign apb_pslverr_o = r_pslverr;
    assign mem_ena_o     = r_mem_ena;
    assign mem_addr_o    = r_mem_addr;
    assign mem_wena_o    = r_mem_wena;
    assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_regf_apb2mem.sv
// -----------------------------------------------------------------------------
// tb_regf_apb2mem
//   Directed bench for regf_apb2mem (ADDRW=13, DATAW=32, RLAT=1).
//   Stimulus pushes expected APB responses and mem accesses into queues;
//   independent monitors pop and compare when the DUT presents pready_o or
//   mem_ena_o. A small regf responder returns data exactly RLAT cycles after
//   mem_ena_o and garbage otherwise.
// -----------------------------------------------------------------------------
module tb_regf_apb2mem;

    localparam int ADDRW = 13;
    localparam int DATAW = 32;

    logic               clk   = 1'b0;
    logic               rst_n = 1'b0;
    logic               psel    = 1'b0;
    logic               penable = 1'b0;
    logic               pwrite  = 1'b0;
    logic [ADDRW+1:0]   paddr   = '0;
    logic [DATAW-1:0]   pwdata  = '0;
`ifdef REGF_APB2MEM_STRB_EN
    logic [DATAW/8-1:0] pstrb   = '1;
`endif
    logic [DATAW-1:0]   prdata;
    logic               pready;
    logic               pslverr;
    logic               mem_ena;
    logic [ADDRW-1:0]   mem_addr;
    logic               mem_wena;
    logic [DATAW-1:0]   mem_wdata;
    logic [DATAW-1:0]   mem_rdata;
    logic               mem_err;

    logic [DATAW-1:0]   rd_val  = '0;
    logic               err_val = 1'b0;

    typedef struct packed {
        logic [DATAW-1:0] prdata;
        logic             pslverr;
    } resp_t;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic             wena;
        logic [DATAW-1:0] wdata;
    } macc_t;

    resp_t resp_q[$];
    macc_t mem_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regf_apb2mem #(
        .ADDRW (ADDRW),
        .DATAW (DATAW),
        .RLAT  (1)
    ) dut (
        .main_clk_i    (clk),
        .main_rst_an_i (rst_n),
        .apb_psel_i    (psel),
        .apb_penable_i (penable),
        .apb_pwrite_i  (pwrite),
        .apb_paddr_i   (paddr),
        .apb_pwdata_i  (pwdata),
`ifdef REGF_APB2MEM_STRB_EN
        .apb_pstrb_i   (pstrb),
`endif
        .apb_prdata_o  (prdata),
        .apb_pready_o  (pready),
        .apb_pslverr_o (pslverr),
        .mem_ena_o     (mem_ena),
        .mem_addr_o    (mem_addr),
        .mem_wena_o    (mem_wena),
        .mem_wdata_o   (mem_wdata),
        .mem_rdata_i   (mem_rdata),
        .mem_err_i     (mem_err)
    );

    // regf responder: answer valid exactly one cycle after mem_ena, garbage otherwise
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_rdata <= '0;
            mem_err   <= 1'b0;
        end else begin
            mem_rdata <= mem_ena ? rd_val  : 32'hDEAD_BEEF;
            mem_err   <= mem_ena ? err_val : 1'b0;
        end
    end

    // APB response monitor
    always @(negedge clk) begin : resp_mon
        resp_t e;
        if (rst_n) begin
            if (pready) begin
                n_vec++;
                if (resp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pready: got prdata=%h pslverr=%b, required no response", prdata, pslverr);
                end else begin
                    e = resp_q.pop_front();
                    if (prdata !== e.prdata || pslverr !== e.pslverr) begin
                        n_err++;
                        $display("FAIL apb_resp: got prdata=%h pslverr=%b, required prdata=%h pslverr=%b",
                                 prdata, pslverr, e.prdata, e.pslverr);
                    end
                end
            end else if (prdata !== '0 || pslverr !== 1'b0) begin
                n_err++;
                $display("FAIL idle_resp_zero: got prdata=%h pslverr=%b, required 0/0", prdata, pslverr);
            end
        end
    end

    // mem-port monitor
    always @(negedge clk) begin : mem_mon
        macc_t m;
        if (rst_n && mem_ena) begin
            n_vec++;
            if (mem_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_mem_ena: got addr=%h wena=%b, required no access", mem_addr, mem_wena);
            end else begin
                m = mem_q.pop_front();
                if (mem_addr !== m.addr || mem_wena !== m.wena ||
                    (m.wena && mem_wdata !== m.wdata)) begin
                    n_err++;
                    $display("FAIL mem_access: got addr=%h wena=%b wdata=%h, required addr=%h wena=%b wdata=%h",
                             mem_addr, mem_wena, mem_wdata, m.addr, m.wena, m.wdata);
                end
            end
        end
    end

    task automatic check_all_zero(input string name);
        n_vec++;
        if (prdata !== '0 || pready !== 1'b0 || pslverr !== 1'b0 || mem_ena !== 1'b0 ||
            mem_addr !== '0 || mem_wena !== 1'b0 || mem_wdata !== '0) begin
            n_err++;
            $display("FAIL %s: got prdata=%h pready=%b pslverr=%b ena=%b addr=%h wena=%b wdata=%h, required all 0",
                     name, prdata, pready, pslverr, mem_ena, mem_addr, mem_wena, mem_wdata);
        end
    endtask

    // One APB transfer; pready is expected exp_cyc cycles after the setup cycle
    task automatic xfer(input string name, input logic wr, input logic [ADDRW+1:0] a,
                        input logic [DATAW-1:0] wd, input logic [DATAW-1:0] rv, input logic ev,
                        input logic exp_mem, input logic [ADDRW-1:0] exp_addr, input int exp_cyc,
                        input logic [DATAW-1:0] exp_rd, input logic exp_err);
        int cyc;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd;
        rd_val = rv; err_val = ev;
        if (exp_mem) mem_q.push_back('{exp_addr, wr, wd});
        resp_q.push_back('{exp_rd, exp_err});
        @(negedge clk);
        penable = 1'b1;
        cyc = 1;
        while (!pready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_vec++;
        if (!pready) begin
            n_err++;
            $display("FAIL %s_timeout: got no pready in %0d cycles, required pready at T%0d", name, cyc, exp_cyc);
        end else if (cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s_latency: got pready at T%0d, required T%0d", name, cyc, exp_cyc);
        end
        $display("xfer %s: wr=%0b paddr=%h pready@T%0d prdata=%h pslverr=%b", name, wr, a, cyc, prdata, pslverr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            psel = 1'b0; penable = 1'b0;
        end
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        idle(2);

        xfer("rd_basic",  1'b0, 15'h0010, 32'h0,        32'hCAFE_0001, 1'b0, 1'b1, 13'h004, 3, 32'hCAFE_0001, 1'b0);
        xfer("wr_b2b",    1'b1, 15'h0008, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b1, 13'h002, 3, 32'h0,         1'b0);
        xfer("rd_mis",    1'b0, 15'h0006, 32'h0,        32'h1111_1111, 1'b0, 1'b0, 13'h000, 1, 32'h0,         1'b1);
        xfer("rd_err",    1'b0, 15'h0020, 32'h0,        32'h5555_AAAA, 1'b1, 1'b1, 13'h008, 3, 32'h5555_AAAA, 1'b1);
        xfer("wr_err",    1'b1, 15'h0024, 32'hA5A5_A5A5, 32'h2222_2222, 1'b1, 1'b1, 13'h009, 3, 32'h0,         1'b1);
        xfer("rd_top",    1'b0, 15'h7FFC, 32'h0,        32'h0BAD_F00D, 1'b0, 1'b1, 13'h1FFF, 3, 32'h0BAD_F00D, 1'b0);
        xfer("wr_mis1",   1'b1, 15'h0001, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b0, 13'h000, 1, 32'h0,         1'b1);
        xfer("rd_mis3",   1'b0, 15'h0003, 32'h0,        32'h3333_3333, 1'b0, 1'b0, 13'h000, 1, 32'h0,         1'b1);
        idle(2);

        // Master drops psel after setup: mem access still happens, no response
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 15'h0040;
        rd_val = 32'h7777_7777; err_val = 1'b0;
        mem_q.push_back('{13'h010, 1'b0, 32'h0});
        idle(6);
        $display("xfer psel_drop: paddr=%h no response expected", 15'h0040);
        xfer("rd_after_drop", 1'b0, 15'h0044, 32'h0, 32'h4444_0044, 1'b0, 1'b1, 13'h011, 3, 32'h4444_0044, 1'b0);
        idle(2);

        // Reset while the FSM is in WAIT
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 15'h0050;
        rd_val = 32'h5050_5050; err_val = 1'b0;
        mem_q.push_back('{13'h014, 1'b0, 32'h0});
        @(negedge clk);
        penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("reset_in_wait");
        $display("xfer reset_in_wait: paddr=%h aborted by reset", 15'h0050);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        xfer("rd_after_rst", 1'b0, 15'h0060, 32'h0, 32'h6060_0606, 1'b0, 1'b1, 13'h018, 3, 32'h6060_0606, 1'b0);
        idle(2);

`ifdef REGF_APB2MEM_STRB_EN
        pstrb = 4'b0011;
        xfer("wr_strb_part", 1'b1, 15'h0030, 32'hDEAD_0030, 32'h0, 1'b0, 1'b0, 13'h000, 1, 32'h0, 1'b1);
        pstrb = 4'hF;
        xfer("wr_strb_full", 1'b1, 15'h0030, 32'hBEEF_0030, 32'h0, 1'b0, 1'b1, 13'h00C, 3, 32'h0, 1'b0);
        pstrb = 4'b0001;
        xfer("rd_strb_ign",  1'b0, 15'h0034, 32'h0, 32'h3434_3434, 1'b0, 1'b1, 13'h00D, 3, 32'h3434_3434, 1'b0);
        pstrb = 4'hF;
        idle(2);
`endif

        idle(4);
        n_vec++;
        if (resp_q.size() != 0) begin
            n_err++;
            $display("FAIL resp_queue_drain: got %0d pending responses, required 0", resp_q.size());
        end
        n_vec++;
        if (mem_q.size() != 0) begin
            n_err++;
            $display("FAIL mem_queue_drain: got %0d pending mem accesses, required 0", mem_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
